// File: rtl/vc_dest_arbiter.sv
// Strict-priority mover from two show-ahead VC FIFOs into two destination FIFOs,
// routed by one word bit, with almost-full backpressure and per-destination counters.
module vc_dest_arbiter #(
    parameter int unsigned DATA_W   = 6,
    parameter int unsigned DEST_BIT = 4,
    parameter int unsigned CNT_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              vc0_empty,
    input  logic [DATA_W-1:0] vc0_data,
    input  logic              vc1_empty,
    input  logic [DATA_W-1:0] vc1_data,
    input  logic              d0_almost_full,
    input  logic              d1_almost_full,
    output logic              vc0_pop,
    output logic              vc1_pop,
    output logic              d0_push,
    output logic [DATA_W-1:0] d0_data,
    output logic              d1_push,
    output logic [DATA_W-1:0] d1_data,
    output logic [CNT_W-1:0]  cnt_d0,
    output logic [CNT_W-1:0]  cnt_d1,
    output logic              busy
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                d0_push_q, d1_push_q;
    logic [DATA_W-1:0]   d0_data_q, d1_data_q;
    logic [CNT_W-1:0]    cnt_d0_q, cnt_d1_q;
    logic                busy_q;

    logic                run_ok;
    logic                vc0_blocked, vc1_blocked;
    logic                any_pop;
    logic [DATA_W-1:0]   sel_word;
    logic                sel_dest;

    // Grant: reset also gates pops so nothing is consumed while it is asserted.
    always_comb begin
        run_ok      = (state_q == RUN) && active && reset;
        vc0_blocked = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        vc1_blocked = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        vc0_pop     = run_ok && !vc0_empty && !vc0_blocked;
        vc1_pop     = run_ok && !vc1_empty && !vc1_blocked && !vc0_pop;
        any_pop     = vc0_pop || vc1_pop;
        sel_word    = vc0_pop ? vc0_data : vc1_data;
        sel_dest    = sel_word[DEST_BIT];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (active)  state_d = RUN;
            RUN:     if (!active) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            d0_push_q <= 1'b0;
            d1_push_q <= 1'b0;
            d0_data_q <= '0;
            d1_data_q <= '0;
            cnt_d0_q  <= '0;
            cnt_d1_q  <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d == RUN);
            d0_push_q <= any_pop && !sel_dest;
            d1_push_q <= any_pop && sel_dest;
            if (any_pop && !sel_dest) d0_data_q <= sel_word;
            if (any_pop && sel_dest)  d1_data_q <= sel_word;
            // Counters wrap naturally at 2^CNT_W.
            if (d0_push_q) cnt_d0_q <= cnt_d0_q + CNT_W'(1);
            if (d1_push_q) cnt_d1_q <= cnt_d1_q + CNT_W'(1);
        end
    end

    assign d0_push = d0_push_q;
    assign d1_push = d1_push_q;
    assign d0_data = d0_data_q;
    assign d1_data = d1_data_q;
    assign cnt_d0  = cnt_d0_q;
    assign cnt_d1  = cnt_d1_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Directed, table-driven bench for vc_dest_arbiter with hand-written
// sequences for reset, active drop, and counter wrap.
module tb_vc_dest_arbiter;

    logic       clk;
    logic       reset;
    logic       active;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_data, vc1_data;
    logic       d0_almost_full, d1_almost_full;
    logic       vc0_pop, vc1_pop;
    logic       d0_push, d1_push;
    logic [5:0] d0_data, d1_data;
    logic [4:0] cnt_d0, cnt_d1;
    logic       busy;

    int tests;
    int fails;

    vc_dest_arbiter #(.DATA_W(6), .DEST_BIT(4), .CNT_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .active         (active),
        .vc0_empty      (vc0_empty),
        .vc0_data       (vc0_data),
        .vc1_empty      (vc1_empty),
        .vc1_data       (vc1_data),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .vc0_pop        (vc0_pop),
        .vc1_pop        (vc1_pop),
        .d0_push        (d0_push),
        .d0_data        (d0_data),
        .d1_push        (d1_push),
        .d1_data        (d1_data),
        .cnt_d0         (cnt_d0),
        .cnt_d1         (cnt_d1),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       act;
        logic       e0;
        logic [5:0] w0;
        logic       e1;
        logic [5:0] w1;
        logic       af0;
        logic       af1;
        logic       p0;
        logic       p1;
        logic       q0;
        logic       q1;
        logic [5:0] dq;
        logic [4:0] c0;
        logic [4:0] c1;
    } vec_t;

    vec_t vecs [14];
    logic [5:0] last_d0, last_d1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic a, input logic e0, input logic [5:0] w0,
                          input logic e1, input logic [5:0] w1,
                          input logic af0, input logic af1);
        active         = a;
        vc0_empty      = e0;
        vc0_data       = w0;
        vc1_empty      = e1;
        vc1_data       = w1;
        d0_almost_full = af0;
        d1_almost_full = af1;
    endtask

    initial begin
        tests = 0;
        fails = 0;

        //           act   e0    w0     e1    w1     af0   af1   p0    p1    q0    q1    dq     c0    c1
        vecs[0]  = '{1'b1, 1'b0, 6'h05, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'h05, 5'd0, 5'd0};
        vecs[1]  = '{1'b1, 1'b0, 6'h12, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h12, 5'd1, 5'd0};
        vecs[2]  = '{1'b1, 1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 5'd1, 5'd1};
        vecs[3]  = '{1'b1, 1'b0, 6'h11, 1'b0, 6'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h03, 5'd1, 5'd1};
        vecs[4]  = '{1'b1, 1'b0, 6'h11, 1'b1, 6'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6'h11, 5'd2, 5'd1};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{1'b1, 1'b0, 6'h11, 1'b0, 6'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 5'd2, 5'd2};
        vecs[10] = '{1'b1, 1'b0, 6'h11, 1'b0, 6'h03, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h03, 5'd2, 5'd2};
        vecs[11] = '{1'b1, 1'b0, 6'h11, 1'b0, 6'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'h05, 5'd3, 5'd2};
        vecs[12] = '{1'b1, 1'b0, 6'h11, 1'b1, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 5'd4, 5'd2};
        vecs[13] = '{1'b1, 1'b0, 6'h07, 1'b1, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h07, 5'd4, 5'd2};

        // Reset held for two edges with work available and active high.
        reset = 1'b0;
        set_in(1'b1, 1'b0, 6'h05, 1'b0, 6'h03, 1'b0, 1'b0);
        #1;
        chk("rst_pop0_pre", 32'(vc0_pop), 32'd0);
        chk("rst_pop1_pre", 32'(vc1_pop), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_push0", 32'(d0_push), 32'd0);
            chk("rst_push1", 32'(d1_push), 32'd0);
            chk("rst_cnt0",  32'(cnt_d0),  32'd0);
            chk("rst_cnt1",  32'(cnt_d1),  32'd0);
            chk("rst_busy",  32'(busy),    32'd0);
            chk("rst_data0", 32'(d0_data), 32'd0);
            chk("rst_data1", 32'(d1_data), 32'd0);
            chk("rst_pop0",  32'(vc0_pop), 32'd0);
            chk("rst_pop1",  32'(vc1_pop), 32'd0);
        end

        // Leave reset with nothing queued; active sampled here enters RUN.
        reset = 1'b1;
        set_in(1'b1, 1'b1, 6'h00, 1'b1, 6'h00, 1'b0, 1'b0);
        tick();
        chk("run_busy", 32'(busy), 32'd1);
        last_d0 = 6'h00;
        last_d1 = 6'h00;

        // Table: routing, priority/bypass, backpressure.
        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].act, vecs[i].e0, vecs[i].w0, vecs[i].e1, vecs[i].w1,
                   vecs[i].af0, vecs[i].af1);
            #1;
            chk($sformatf("v%0d_pop0", i), 32'(vc0_pop), 32'(vecs[i].p0));
            chk($sformatf("v%0d_pop1", i), 32'(vc1_pop), 32'(vecs[i].p1));
            tick();
            if (vecs[i].q0) last_d0 = vecs[i].dq;
            if (vecs[i].q1) last_d1 = vecs[i].dq;
            chk($sformatf("v%0d_push0", i), 32'(d0_push), 32'(vecs[i].q0));
            chk($sformatf("v%0d_push1", i), 32'(d1_push), 32'(vecs[i].q1));
            chk($sformatf("v%0d_data0", i), 32'(d0_data), 32'(last_d0));
            chk($sformatf("v%0d_data1", i), 32'(d1_data), 32'(last_d1));
            chk($sformatf("v%0d_cnt0",  i), 32'(cnt_d0),  32'(vecs[i].c0));
            chk($sformatf("v%0d_cnt1",  i), 32'(cnt_d1),  32'(vecs[i].c1));
            chk($sformatf("v%0d_busy",  i), 32'(busy),    32'd1);
        end

        // Active fell at the edge that popped 0x07: no more pops, RUN exits.
        set_in(1'b0, 1'b0, 6'h05, 1'b0, 6'h03, 1'b0, 1'b0);
        #1;
        chk("drop_pop0", 32'(vc0_pop), 32'd0);
        chk("drop_pop1", 32'(vc1_pop), 32'd0);
        tick();
        chk("drop_busy",  32'(busy),    32'd0);
        chk("drop_push0", 32'(d0_push), 32'd0);
        chk("drop_push1", 32'(d1_push), 32'd0);
        chk("drop_cnt0",  32'(cnt_d0),  32'd5);
        chk("drop_data0", 32'(d0_data), 32'h07);
        #1;
        chk("idle_pop0", 32'(vc0_pop), 32'd0);

        // Re-enter RUN: first pop only in the cycle after active rises.
        set_in(1'b1, 1'b0, 6'h05, 1'b1, 6'h00, 1'b0, 1'b0);
        #1;
        chk("enter_pop0_idle", 32'(vc0_pop), 32'd0);
        tick();
        chk("enter_busy", 32'(busy), 32'd1);
        #1;
        chk("enter_pop0_run", 32'(vc0_pop), 32'd1);
        tick();
        chk("enter_push0", 32'(d0_push), 32'd1);
        chk("enter_cnt0",  32'(cnt_d0),  32'd5);

        // Reset while a push is pending: push and counters clear.
        reset = 1'b0;
        #1;
        chk("mid_rst_pop0", 32'(vc0_pop), 32'd0);
        tick();
        chk("mid_rst_push0", 32'(d0_push), 32'd0);
        chk("mid_rst_cnt0",  32'(cnt_d0),  32'd0);
        chk("mid_rst_cnt1",  32'(cnt_d1),  32'd0);
        chk("mid_rst_busy",  32'(busy),    32'd0);
        chk("mid_rst_data0", 32'(d0_data), 32'd0);

        // Counter wrap: 33 back-to-back pops of a D0 word.
        reset = 1'b1;
        set_in(1'b1, 1'b0, 6'h05, 1'b1, 6'h00, 1'b0, 1'b0);
        #1;
        chk("wrap_pop0_idle", 32'(vc0_pop), 32'd0);
        tick();
        for (int c = 1; c <= 34; c++) begin
            vc0_empty = (c > 33);
            #1;
            chk($sformatf("wrap%0d_pop0", c), 32'(vc0_pop), 32'(c <= 33));
            tick();
            chk($sformatf("wrap%0d_push0", c), 32'(d0_push), 32'(c <= 33));
            chk($sformatf("wrap%0d_cnt0",  c), 32'(cnt_d0),  32'((c - 1) % 32));
        end
        chk("wrap_cnt1", 32'(cnt_d1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vc_dest_arbiter.md
# vc_dest_arbiter

Moves words from the two virtual-channel FIFOs (VC0, VC1) into the two destination FIFOs (D0, D1). It sits between the VC FIFO stage and the destination FIFO stage of the datapath. It is enabled by the top-level controller's active indication. Each cycle it pops at most one word:
- VC0 has strict priority over VC1.
- The destination is selected by one bit of the word.
- Each destination's almost-full flag provides backpressure.

## Interface
- DATA_W, 6, word width for VC and D FIFO data.
- DEST_BIT, 4, bit index in the word that selects the destination: 0 selects D0, 1 selects D1.
- CNT_W, 5, width of the per-destination forwarded-word counters.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- active  in  1  enable from the top-level controller; no new pops while low.
- vc0_empty  in  1  VC0 FIFO empty.
- vc0_data  in  DATA_W  VC0 head word (show-ahead); valid when vc0_empty=0.
- vc1_empty  in  1  VC1 FIFO empty.
- vc1_data  in  DATA_W  VC1 head word (show-ahead); valid when vc1_empty=0.
- d0_almost_full  in  1  D0 FIFO at or above its high threshold.
- d1_almost_full  in  1  D1 FIFO at or above its high threshold.
- vc0_pop  out  1  combinational; consumes the VC0 head at this edge.
- vc1_pop  out  1  combinational; consumes the VC1 head at this edge.
- d0_push  out  1  registered write strobe to D0.
- d0_data  out  DATA_W  registered write data to D0.
- d1_push  out  1  registered write strobe to D1.
- d1_data  out  DATA_W  registered write data to D1.
- cnt_d0  out  CNT_W  words pushed to D0 since reset.
- cnt_d1  out  CNT_W  words pushed to D1 since reset.
- busy  out  1  registered; high in RUN state.

## Operation
- Two-state machine, IDLE and RUN.
  - IDLE to RUN when active=1.
  - RUN to IDLE when active=0.
  - Reset forces IDLE.
- Eligibility:
  - VC0 is eligible when: state=RUN, active=1, vc0_empty=0, and the almost_full flag of D[vc0_data[DEST_BIT]] is 0.
  - VC1 is eligible by the same rule using its own head word.
- Grant rules:
  - vc0_pop = VC0 eligible.
  - vc1_pop = VC1 eligible and not vc0_pop.
  - Never both pops in the same cycle.
- No head-of-line blocking across VCs. If VC0 is non-empty but its destination is almost full, VC1 is granted when VC1 is eligible.
- The popped word and its destination are registered at the pop edge.
- Next cycle, exactly one of d0_push/d1_push is high, with the matching d*_data equal to the popped word. The other push is 0.
- d*_data holds its last value when the corresponding push is 0.
- cnt_dX increments by 1 on every cycle with dX_push=1. It wraps modulo 2^CNT_W (31 to 0 at CNT_W=5).
- active falling with a word in flight: the in-flight push still completes on the next cycle, and no further pops occur.
- The almost_full thresholds are programmed by the controller with one word of headroom for the in-flight slot. This block does not check for overflow.

## Timing
- Reset (reset=0 at an edge): state=IDLE, busy=0, d0_push=d1_push=0, d0_data=d1_data=0, cnt_d0=cnt_d1=0, and the in-flight word is discarded.
  - vc0_pop and vc1_pop are 0 while reset=0 and until state=RUN.
- Entering RUN: active is sampled at edge N, giving state=RUN and busy=1 after edge N. The first pop can therefore be asserted in the cycle after active first rises.
- Pop-to-push latency: a pop at edge N produces a push visible in cycle N+1, which writes the destination FIFO at edge N+1.
- Counter update: the counter increments at the edge where push=1 is sampled.
  - Its value is visible 2 cycles after the pop.
- Throughput: 1 word per cycle sustained while at least one source is eligible.
- Almost-full response: pops to a destination stop in the same cycle its almost_full rises (combinational).
- Reset mid-operation: push is 0 in the cycle following the reset edge. Counters read 0.

## Test plan
- Reset: hold reset=0 for 2 cycles with both VCs non-empty and active=1.
  - Required: all pops and pushes stay 0, both counters 0, busy=0.
- Basic routing: active=1, VC0 holds 0x05 (bit4=0) then 0x12 (bit4=1), VC1 empty.
  - Required: vc0_pop for 2 consecutive cycles.
  - Required: d0_push with data 0x05 one cycle after the first pop, then d1_push with data 0x12.
  - Required: cnt_d0=1, cnt_d1=1.
- Priority and bypass: both VCs non-empty, VC0 head 0x11 with d1_almost_full=1, VC1 head 0x03.
  - Required: vc1_pop=1, vc0_pop=0, d0_push with 0x03 next cycle.
  - Then drop d1_almost_full. Required: vc0_pop=1 and d1_push with 0x11.
- Backpressure: both almost_full flags high with both VCs non-empty for 5 cycles.
  - Required: no pops and no pushes.
  - Release d0_almost_full only. Required: only words routed to D0 are popped.
- active drop mid-stream: deassert active in the same cycle as a pop of 0x07.
  - Required: d0_push with 0x07 on the next cycle, no further pops, busy=0 one cycle after active falls.
- Counter wrap: push 33 words to D0.
  - Required: cnt_d0 reads 31 after 31 pushes, 0 after 32, 1 after 33.
